// File: rtl/v_cu_pkg.sv
// Shared types and helpers for the vector control unit: element width,
// sequencer FSM states, elements-per-beat and tail byte-enable computation.
package v_cu_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } sew_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } pgs_state_e;

    // The reserved encoding 3 behaves as 32-bit elements.
    function automatic sew_e sew_norm(input logic [1:0] raw);
        return (raw == 2'd3) ? SEW32 : sew_e'(raw);
    endfunction

    function automatic int unsigned epb_f(input int unsigned lanes, input sew_e sew);
        return lanes << (2 - int'(sew));
    endfunction

    function automatic logic [63:0] tail_be_f(input int unsigned lanes, input sew_e sew,
                                             input int unsigned vl);
        int unsigned epb;
        int unsigned rem;
        int unsigned nbytes;
        epb    = epb_f(lanes, sew);
        rem    = vl & (epb - 32'd1);
        nbytes = ((rem == 32'd0) ? epb : rem) << int'(sew);
        return (nbytes >= 32'd64) ? {64{1'b1}} : ((64'd1 << nbytes) - 64'd1);
    endfunction

endpackage

// File: rtl/v_port_group_sequencer_if.sv
// Allocator / VRF handshake bundle for one write-port group sequencer.
interface v_port_group_sequencer_if #(
    parameter int LANES  = 4,
    parameter int VL_W   = 12,
    parameter int ADDR_W = 9
);
    logic                  start_i;
    logic                  port_rdy_o;
    logic [VL_W-1:0]       vl_i;
    logic [1:0]            sew_i;
    logic [ADDR_W-1:0]     vs1_addr_i;
    logic [ADDR_W-1:0]     vs2_addr_i;
    logic [ADDR_W-1:0]     vd_addr_i;
    logic                  stall_i;
    logic                  rd_en_o;
    logic [ADDR_W-1:0]     rd_addr1_o;
    logic [ADDR_W-1:0]     rd_addr2_o;
    logic                  wr_en_o;
    logic [ADDR_W-1:0]     wr_addr_o;
    logic [LANES*4-1:0]    wr_be_o;
    logic                  done_o;

    modport master (
        output start_i, vl_i, sew_i, vs1_addr_i, vs2_addr_i, vd_addr_i, stall_i,
        input  port_rdy_o, rd_en_o, rd_addr1_o, rd_addr2_o,
               wr_en_o, wr_addr_o, wr_be_o, done_o
    );

    modport slave (
        input  start_i, vl_i, sew_i, vs1_addr_i, vs2_addr_i, vd_addr_i, stall_i,
        output port_rdy_o, rd_en_o, rd_addr1_o, rd_addr2_o,
               wr_en_o, wr_addr_o, wr_be_o, done_o
    );
endinterface

// File: rtl/v_pgs_delay_line.sv
// Stall-aware fixed-latency shift register carrying {valid, last, be} from
// the read beat to its matching write-back beat.
module v_pgs_delay_line #(
    parameter int PIPE_LAT = 3,
    parameter int BE_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_adv,
    input  logic            i_valid,
    input  logic            i_last,
    input  logic [BE_W-1:0] i_be,
    output logic            o_valid,
    output logic            o_last,
    output logic [BE_W-1:0] o_be
);
    localparam int STG_W = BE_W + 2;

    logic [STG_W-1:0] r_stg [PIPE_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) r_stg[i] <= '0;
        end else if (i_adv) begin
            r_stg[0] <= {i_valid, i_last, i_be};
            for (int i = 1; i < PIPE_LAT; i++) r_stg[i] <= r_stg[i-1];
        end
    end

    assign {o_valid, o_last, o_be} = r_stg[PIPE_LAT-1];
endmodule

// File: rtl/v_port_group_sequencer.sv
// Write-port group sequencer: issues VRF read beats, delays them by PIPE_LAT
// and issues write-back beats. V_PGS_PERF_CNT_EN adds busy/stall counters.
module v_port_group_sequencer
    import v_cu_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int VL_W     = 12,
    parameter int ADDR_W   = 9,
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
`ifdef V_PGS_PERF_CNT_EN
    output logic [31:0] busy_cycles_o,
    output logic [31:0] stall_cycles_o,
`endif
    v_port_group_sequencer_if.slave bus
);
    localparam int BE_W = LANES * 4;
    localparam int LG_L = $clog2(LANES);

    pgs_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_vs1, r_vs2, r_vd, r_wr_idx;
    logic [VL_W-1:0]   r_beats, r_rd_idx;
    logic [BE_W-1:0]   r_last_be;
    logic              r_zero_done;

    sew_e              w_sew;
    int                w_shift;
    logic [VL_W-1:0]   w_beats;
    logic [BE_W-1:0]   w_tail_be;
    logic              w_port_rdy, w_accept, w_vl_zero, w_rd_en, w_rd_last;
    logic              w_dl_valid, w_dl_last;
    logic [BE_W-1:0]   w_dl_be;

    always_comb begin
        w_sew     = sew_norm(bus.sew_i);
        w_shift   = LG_L + 2 - int'(w_sew);
        w_beats   = VL_W'((32'(bus.vl_i) + epb_f(LANES, w_sew) - 32'd1) >> w_shift);
        w_tail_be = BE_W'(tail_be_f(LANES, w_sew, 32'(bus.vl_i)));
        w_vl_zero = (bus.vl_i == '0);
        w_port_rdy = (r_state == ST_IDLE) && !r_zero_done;
        w_accept  = bus.start_i && w_port_rdy && !bus.stall_i;
        w_rd_en   = (r_state == ST_READ) && !bus.stall_i;
        w_rd_last = (r_rd_idx == r_beats - VL_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && !w_vl_zero) w_state_nxt = ST_READ;
            ST_READ:  if (w_rd_en && w_rd_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!bus.stall_i && w_dl_valid && w_dl_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.port_rdy_o = w_port_rdy;
        bus.rd_en_o    = w_rd_en;
        bus.rd_addr1_o = r_vs1 + ADDR_W'(r_rd_idx);
        bus.rd_addr2_o = r_vs2 + ADDR_W'(r_rd_idx);
        bus.wr_en_o    = w_dl_valid && !bus.stall_i;
        bus.wr_addr_o  = r_vd + r_wr_idx;
        bus.wr_be_o    = w_dl_be;
        bus.done_o     = !bus.stall_i && (r_zero_done || (w_dl_valid && w_dl_last));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs1       <= '0;
            r_vs2       <= '0;
            r_vd        <= '0;
            r_beats     <= '0;
            r_rd_idx    <= '0;
            r_wr_idx    <= '0;
            r_last_be   <= '0;
            r_zero_done <= 1'b0;
        end else if (!bus.stall_i) begin
            r_zero_done <= 1'b0;
            if (w_accept) begin
                r_vs1       <= bus.vs1_addr_i;
                r_vs2       <= bus.vs2_addr_i;
                r_vd        <= bus.vd_addr_i;
                r_beats     <= w_beats;
                r_last_be   <= w_tail_be;
                r_rd_idx    <= '0;
                r_wr_idx    <= '0;
                r_zero_done <= w_vl_zero;
            end
            if (w_rd_en)     r_rd_idx <= r_rd_idx + VL_W'(1);
            if (bus.wr_en_o) r_wr_idx <= r_wr_idx + ADDR_W'(1);
        end
    end

    v_pgs_delay_line #(
        .PIPE_LAT (PIPE_LAT),
        .BE_W     (BE_W)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (!bus.stall_i),
        .i_valid (w_rd_en),
        .i_last  (w_rd_last),
        .i_be    (w_rd_last ? r_last_be : {BE_W{1'b1}}),
        .o_valid (w_dl_valid),
        .o_last  (w_dl_last),
        .o_be    (w_dl_be)
    );

`ifdef V_PGS_PERF_CNT_EN
    logic [31:0] r_busy_cnt, r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt  <= '0;
            r_stall_cnt <= '0;
        end else if (!w_port_rdy) begin
            if (r_busy_cnt != '1) r_busy_cnt <= r_busy_cnt + 32'd1;
            if (bus.stall_i && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign busy_cycles_o  = r_busy_cnt;
    assign stall_cycles_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_v_port_group_sequencer.sv
// Scoreboard bench for v_port_group_sequencer: expected read/write/done
// events are predicted at start time and matched as the DUT emits them.
module tb_v_port_group_sequencer;
    localparam int LANES    = 4;
    localparam int PIPE_LAT = 3;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    ev_t  rd_q[$];
    ev_t  wr_q[$];
    int   done_q[$];
    ev_t  mon_e;

    v_port_group_sequencer_if #(.LANES(LANES), .VL_W(12), .ADDR_W(9)) bus();

`ifdef V_PGS_PERF_CNT_EN
    logic [31:0] busy_cycles, stall_cycles;
`endif

    v_port_group_sequencer #(
        .LANES(LANES), .VL_W(12), .ADDR_W(9), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef V_PGS_PERF_CNT_EN
        .busy_cycles_o  (busy_cycles),
        .stall_cycles_o (stall_cycles),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_stall(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Predict event cycles: each read takes the next unstalled cycle; its write
    // lands on the PIPE_LAT-th unstalled cycle after it. Events at or after
    // 'cut' are dropped (reset aborts the operation).
    task automatic model_push(input int c0, input int vl, input int sew, input int a1,
                              input int a2, input int ad, input int lo, input int hi,
                              input int cut, output int done_cyc);
        int s, epb, beats, c, wc, n, elems, nbytes, be;
        s     = (sew == 3) ? 2 : sew;
        epb   = LANES << (2 - s);
        beats = (vl + epb - 1) / epb;
        c     = c0;
        wc    = c0 + 1;
        for (int b = 0; b < beats; b++) begin
            c++;
            while (in_stall(c, lo, hi)) c++;
            wc = c;
            n  = 0;
            while (n < PIPE_LAT) begin
                wc++;
                if (!in_stall(wc, lo, hi)) n++;
            end
            elems  = (b == beats - 1) ? vl - b * epb : epb;
            nbytes = elems << s;
            be     = (nbytes >= 16) ? 'hFFFF : ((1 << nbytes) - 1);
            if (c < cut)  rd_q.push_back('{c, (a1 + b) & 'h1FF, (a2 + b) & 'h1FF});
            if (wc < cut) wr_q.push_back('{wc, (ad + b) & 'h1FF, be});
        end
        done_cyc = wc;
        if (done_cyc < cut) done_q.push_back(done_cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_en_o) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    mon_e = rd_q.pop_front();
                    chk("rd_cycle", cyc, mon_e.cyc);
                    chk("rd_addr1", int'(bus.rd_addr1_o), mon_e.a);
                    chk("rd_addr2", int'(bus.rd_addr2_o), mon_e.b);
                end
            end
            if (bus.wr_en_o) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    mon_e = wr_q.pop_front();
                    chk("wr_cycle", cyc, mon_e.cyc);
                    chk("wr_addr", int'(bus.wr_addr_o), mon_e.a);
                    chk("wr_be", int'(bus.wr_be_o), mon_e.b);
                end
            end
            if (bus.done_o) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic check_drained(input string tag);
        chk({tag, "_rd_left"}, rd_q.size(), 0);
        chk({tag, "_wr_left"}, wr_q.size(), 0);
        chk({tag, "_done_left"}, done_q.size(), 0);
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
    endtask

    // st_lo/st_hi: stall window relative to start (st_lo<0: none);
    // rs_at: relative cycle of a spurious second start (<=0: none).
    task automatic run_op(input string tag, input int vl, input int sew, input int a1,
                          input int a2, input int ad, input int st_lo, input int st_hi,
                          input int rs_at);
        int c0, dc, lo, hi;
        bit fin;
        @(posedge clk); #1;
        c0 = cyc;
        lo = (st_lo < 0) ? -1 : c0 + st_lo;
        hi = (st_lo < 0) ? -2 : c0 + st_hi;
        model_push(c0, vl, sew, a1, a2, ad, lo, hi, 1 << 30, dc);
        chk({tag, "_rdy_idle"}, int'(bus.port_rdy_o), 1);
        bus.start_i    = 1'b1;
        bus.vl_i       = 12'(vl);
        bus.sew_i      = 2'(sew);
        bus.vs1_addr_i = 9'(a1);
        bus.vs2_addr_i = 9'(a2);
        bus.vd_addr_i  = 9'(ad);
        fin = 1'b0;
        for (int k = 0; k < 80 && !fin; k++) begin
            @(posedge clk); #1;
            bus.start_i = (rs_at > 0) && (cyc == c0 + rs_at);
            if (bus.start_i) begin
                bus.vl_i       = 12'd3;
                bus.vs1_addr_i = 9'h0;
                bus.vd_addr_i  = 9'h100;
            end
            bus.stall_i = in_stall(cyc, lo, hi);
            chk({tag, "_port_rdy"}, int'(bus.port_rdy_o), (cyc > c0 && cyc <= dc) ? 0 : 1);
            if (cyc > dc) fin = 1'b1;
        end
        if (!fin) chk({tag, "_timeout"}, 0, 1);
        bus.start_i = 1'b0;
        bus.stall_i = 1'b0;
        check_drained(tag);
    endtask

    initial begin
        int c0, dc;
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.stall_i    = 1'b0;
        bus.vl_i       = '0;
        bus.sew_i      = '0;
        bus.vs1_addr_i = '0;
        bus.vs2_addr_i = '0;
        bus.vd_addr_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy", int'(bus.port_rdy_o), 1);
        chk("reset_rd_en", int'(bus.rd_en_o), 0);
        chk("reset_wr_en", int'(bus.wr_en_o), 0);
        chk("reset_done", int'(bus.done_o), 0);
        rst = 1'b0;

        run_op("basic",   10, 2, 'h10, 'h20, 'h40, -1, -1, 0);
        run_op("vl0",      0, 2, 'h10, 'h20, 'h40, -1, -1, 0);
        run_op("sew8",    20, 0, 'h30, 'h50, 'h70, -1, -1, 0);
        run_op("stall",   10, 2, 'h10, 'h20, 'h40,  2,  3, 0);
        run_op("restart", 10, 2, 'h10, 'h20, 'h40, -1, -1, 2);
        run_op("sew16",    7, 1, 'h05, 'h06, 'h07, -1, -1, 0);
        run_op("sew3",     8, 3, 'h11, 'h22, 'h33, -1, -1, 0);
        run_op("wrap",    10, 2, 'h1FF, 'h1FE, 'h1FF, -1, -1, 0);
        run_op("lstall",  10, 2, 'h10, 'h20, 'h40,  6,  6, 0);

        // Reset in the middle of the write drain.
        @(posedge clk); #1;
        c0 = cyc;
        model_push(c0, 10, 2, 'h10, 'h20, 'h40, -1, -2, c0 + 5, dc);
        bus.start_i    = 1'b1;
        bus.vl_i       = 12'd10;
        bus.sew_i      = 2'd2;
        bus.vs1_addr_i = 9'h10;
        bus.vs2_addr_i = 9'h20;
        bus.vd_addr_i  = 9'h40;
        repeat (5) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst_rdy", int'(bus.port_rdy_o), 1);
        chk("midrst_wr_en", int'(bus.wr_en_o), 0);
        chk("midrst_done", int'(bus.done_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_drained("midrst");
        repeat (3) @(posedge clk);
        run_op("after_rst", 10, 2, 'h10, 'h20, 'h40, -1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
